// File: rtl/systolic_array_sequencer.sv
// Sequencer for a ROWS x COLS PE grid: clears the array, issues skewed
// row/column operand-valid slots, waits for every PE to report done (with a
// timeout), then drains the accumulators one column at a time.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, k_len_i    job command and reduction length (IDLE only)
//   busy_o, done_o      job in progress / one-cycle completion pulse
//   error_o             sticky WAIT_DONE timeout flag
//   pe_clear_o          one-cycle array clear
//   slot_o              current feed slot index
//   row_/col_valid_o    per-lane operand valid for the current slot
//   row_/col_last_o     per-lane final-element marker
//   pe_done_i           per-PE done, bit r*COLS+c
//   acc_sel_o           one-hot column accumulator select during drain
//   drain_ack_i         per-column capture acknowledge
module systolic_array_sequencer #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned K_MAX          = 256,
  parameter int unsigned ISSUE_GAP      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [$clog2(K_MAX+1)-1:0]             k_len_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   error_o,
  output logic                                   pe_clear_o,
  output logic [$clog2(K_MAX+ROWS+COLS)-1:0]     slot_o,
  output logic [ROWS-1:0]                        row_valid_o,
  output logic [COLS-1:0]                        col_valid_o,
  output logic [ROWS-1:0]                        row_last_o,
  output logic [COLS-1:0]                        col_last_o,
  input  logic [ROWS*COLS-1:0]                   pe_done_i,
  output logic [COLS-1:0]                        acc_sel_o,
  input  logic [COLS-1:0]                        drain_ack_i
);

  localparam int unsigned KW    = $clog2(K_MAX + 1);
  localparam int unsigned SW    = $clog2(K_MAX + ROWS + COLS);
  localparam int unsigned GW    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned CW    = ((SW > KW) ? SW : KW) + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_WAIT_DONE, S_DRAIN, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [CLW-1:0]  col_q, col_d;
  logic            dgap_q, dgap_d;
  logic            err_q, err_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clear_q, clear_d;
  logic [ROWS-1:0] rv_q, rv_d, rl_q, rl_d;
  logic [COLS-1:0] cv_q, cv_d, cl_q, cl_d;
  logic [COLS-1:0] acc_q, acc_d;

  logic [KW-1:0]   k_sat_c;
  logic            last_slot_c;
  logic            issue_c;

  // Oversized k_len_i saturates to K_MAX.
  assign k_sat_c = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;

  // Final slot index is S-1 = K + max(ROWS,COLS) - 2 (K >= 1 here).
  assign last_slot_c = (CW'(slot_q) == CW'(k_q) + CW'(MAXRC) - CW'(2));

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    dgap_d  = dgap_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (k_len_i == '0) begin
            state_d = S_FINISH;
          end else begin
            k_d     = k_sat_c;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        slot_d  = '0;
        gap_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (gap_q == GW'(ISSUE_GAP - 1)) begin
          gap_d = '0;
          if (last_slot_c) begin
            cnt_d   = '0;
            state_d = S_WAIT_DONE;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_WAIT_DONE: begin
        // All-done takes priority over a coincident timeout.
        if (&pe_done_i) begin
          col_d   = '0;
          dgap_d  = 1'b0;
          state_d = S_DRAIN;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        // One low-select cycle between columns lets the PEs re-gate.
        if (dgap_q) begin
          dgap_d = 1'b0;
          col_d  = col_q + CLW'(1);
        end else if (drain_ack_i[col_q]) begin
          if (col_q == CLW'(COLS - 1)) begin
            state_d = S_FINISH;
          end else begin
            dgap_d = 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is registered.
  assign issue_c = (state_d == S_FEED) && (gap_d == '0);

  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
    clear_d = (state_d == S_CLEAR);
    acc_d   = '0;
    rv_d    = '0;
    rl_d    = '0;
    cv_d    = '0;
    cl_d    = '0;
    if ((state_d == S_DRAIN) && !dgap_d) begin
      acc_d = COLS'(1) << col_d;
    end
    if (issue_c) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        rv_d[r] = (CW'(slot_d) >= CW'(r)) && (CW'(slot_d) < CW'(r) + CW'(k_q));
        rl_d[r] = (CW'(slot_d) == CW'(r) + CW'(k_q) - CW'(1));
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        cv_d[c] = (CW'(slot_d) >= CW'(c)) && (CW'(slot_d) < CW'(c) + CW'(k_q));
        cl_d[c] = (CW'(slot_d) == CW'(c) + CW'(k_q) - CW'(1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      slot_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      dgap_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      rv_q    <= '0;
      rl_q    <= '0;
      cv_q    <= '0;
      cl_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      dgap_q  <= dgap_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clear_q <= clear_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
      cv_q    <= cv_d;
      cl_q    <= cl_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign pe_clear_o  = clear_q;
  assign slot_o      = slot_q;
  assign row_valid_o = rv_q;
  assign col_valid_o = cv_q;
  assign row_last_o  = rl_q;
  assign col_last_o  = cl_q;
  assign acc_sel_o   = acc_q;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench for systolic_array_sequencer: each job's expected output
// events (cycle-stamped) are derived from slot arithmetic and queued; a
// negedge monitor pops and compares whenever the DUT shows activity.
module tb_systolic_array_sequencer;

  localparam int unsigned R   = 2;
  localparam int unsigned C   = 2;
  localparam int unsigned KM  = 8;
  localparam int unsigned G   = 6;
  localparam int unsigned TO  = 16;
  localparam int unsigned KW  = $clog2(KM + 1);
  localparam int unsigned SW  = $clog2(KM + R + C);
  localparam int unsigned NPE = R * C;
  localparam int unsigned MX  = (R > C) ? R : C;

  logic clk_i = 1'b0;
  logic rst_i, start_i;
  logic [KW-1:0]  k_len_i;
  logic busy_o, done_o, error_o, pe_clear_o;
  logic [SW-1:0]  slot_o;
  logic [R-1:0]   row_valid_o, row_last_o;
  logic [C-1:0]   col_valid_o, col_last_o, acc_sel_o, drain_ack_i;
  logic [NPE-1:0] pe_done_i;

  systolic_array_sequencer #(
    .ROWS(R), .COLS(C), .K_MAX(KM), .ISSUE_GAP(G), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .pe_clear_o(pe_clear_o),
    .slot_o(slot_o), .row_valid_o(row_valid_o), .col_valid_o(col_valid_o),
    .row_last_o(row_last_o), .col_last_o(col_last_o), .pe_done_i(pe_done_i),
    .acc_sel_o(acc_sel_o), .drain_ack_i(drain_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         cy;
    logic       busy, done, err, clr, chk_slot;
    int         slot;
    logic [R-1:0] rv, rl;
    logic [C-1:0] cv, cl, acc;
  } ev_t;

  ev_t  expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;
  logic prev_done = 1'b0;

  function automatic ev_t mk(input int cy);
    ev_t e;
    e.cy = cy; e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.clr = 1'b0;
    e.chk_slot = 1'b0; e.slot = 0; e.rv = '0; e.rl = '0; e.cv = '0; e.cl = '0; e.acc = '0;
    return e;
  endfunction

  // Monitor: any visible activity must match the head of the expected queue.
  always @(negedge clk_i) begin
    ev_t e;
    logic ok;
    if (chk_en) begin
      if (prev_done) begin
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
          n_fail++;
          $display("FAIL post_done_idle cyc=%0d: busy=%b done=%b, required 0 0", cyc, busy_o, done_o);
        end
      end
      prev_done = done_o;
      if (pe_clear_o || done_o || (|row_valid_o) || (|col_valid_o) ||
          (|row_last_o) || (|col_last_o) || (|acc_sel_o)) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d: clr=%b done=%b rv=%b cv=%b rl=%b cl=%b acc=%b, required no activity",
                   cyc, pe_clear_o, done_o, row_valid_o, col_valid_o, row_last_o, col_last_o, acc_sel_o);
        end else begin
          e  = expq.pop_front();
          ok = (cyc == e.cy) && (busy_o === e.busy) && (done_o === e.done) &&
               (error_o === e.err) && (pe_clear_o === e.clr) &&
               (row_valid_o === e.rv) && (row_last_o === e.rl) &&
               (col_valid_o === e.cv) && (col_last_o === e.cl) && (acc_sel_o === e.acc) &&
               (!e.chk_slot || (slot_o === SW'(e.slot)));
          if (!ok) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d b%b d%b e%b c%b s%0d rv%b cv%b rl%b cl%b acc%b; required cyc=%0d b%b d%b e%b c%b s%0d rv%b cv%b rl%b cl%b acc%b",
                     cyc, busy_o, done_o, error_o, pe_clear_o, slot_o, row_valid_o, col_valid_o,
                     row_last_o, col_last_o, acc_sel_o,
                     e.cy, e.busy, e.done, e.err, e.clr, e.slot, e.rv, e.cv, e.rl, e.cl, e.acc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d, required %0d", name, cyc, got, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    int agg;
    agg = int'(busy_o) + int'(done_o) + int'(error_o) + int'(pe_clear_o) + int'(slot_o) +
          int'(row_valid_o) + int'(col_valid_o) + int'(row_last_o) + int'(col_last_o) + int'(acc_sel_o);
    check(name, agg, 0);
  endtask

  // mode: 0 normal, 1 timeout (pe_done stuck 1110), 2 done coincides with
  // the last timeout cycle, 3 reset while column 1 selected, 4 stray start in FEED.
  task automatic run_job(input int kin, input int mode);
    int T, K, S, W, D, Deff, endc, spur, rstc, tc;
    int t[C];
    int d[C];
    logic drain;
    logic [NPE-1:0] pd;
    logic [C-1:0]   ack;
    ev_t e;
    @(negedge clk_i);
    T = cyc; spur = -1; rstc = -1; drain = 1'b0; D = 0; S = 0;
    for (int c = 0; c < int'(C); c++) begin t[c] = -100; d[c] = 0; end
    if (kin == 0) begin
      e = mk(T + 1); e.done = 1'b1; expq.push_back(e);
      endc = T + 1;
    end else begin
      K = (kin > int'(KM)) ? int'(KM) : kin;
      S = K + int'(MX) - 1;
      e = mk(T + 1); e.clr = 1'b1; expq.push_back(e);
      for (int s = 0; s < S; s++) begin
        e = mk(T + 2 + s * int'(G)); e.chk_slot = 1'b1; e.slot = s;
        for (int r = 0; r < int'(R); r++) begin
          e.rv[r] = (s - r >= 0) && (s - r < K);
          e.rl[r] = (s - r == K - 1);
        end
        for (int c = 0; c < int'(C); c++) begin
          e.cv[c] = (s - c >= 0) && (s - c < K);
          e.cl[c] = (s - c == K - 1);
        end
        expq.push_back(e);
      end
      W = T + 2 + S * int'(G);
      case (mode)
        1:       D = 1 << 30;
        2:       D = W + int'(TO) - 1;
        default: D = W - 4 + int'($urandom_range(0, 10));
      endcase
      Deff = (D > W) ? D : W;
      if (Deff <= W + int'(TO) - 1) begin
        drain = 1'b1;
        tc = Deff + 1;
        endc = -1;
        for (int c = 0; c < int'(C); c++) begin
          d[c] = (mode == 3 && c == 1) ? 3 : int'($urandom_range(0, 3));
          t[c] = tc;
          if (mode == 3 && c == 1) begin
            for (int j = 0; j < 2; j++) begin
              e = mk(tc + j); e.acc = C'(1) << c; expq.push_back(e);
            end
            rstc = tc + 1;
            endc = tc + 2;
            break;
          end
          for (int j = 0; j <= d[c]; j++) begin
            e = mk(tc + j); e.acc = C'(1) << c; expq.push_back(e);
          end
          tc = tc + d[c] + 2;
        end
        if (endc < 0) begin
          endc = tc - 1;
          e = mk(endc); e.done = 1'b1; expq.push_back(e);
        end
      end else begin
        endc = W + int'(TO);
        e = mk(endc); e.done = 1'b1; e.err = 1'b1; expq.push_back(e);
      end
      if (mode == 4) spur = T + 2 + int'($urandom_range(0, S * int'(G) - 1));
    end
    start_i = 1'b1;
    k_len_i = KW'(kin);
    do begin
      @(negedge clk_i);
      start_i = (cyc == spur);
      if (cyc == spur) k_len_i = KW'($urandom);
      rst_i = (cyc == rstc);
      if (mode == 1) begin
        pe_done_i = NPE'(4'b1110);
      end else if (kin != 0 && cyc >= D) begin
        pe_done_i = '1;
      end else begin
        pd = NPE'($urandom);
        pd[$urandom_range(0, NPE - 1)] = 1'b0;
        pe_done_i = pd;
      end
      ack = '0;
      if (drain) begin
        for (int c = 0; c < int'(C); c++) begin
          if (cyc >= t[c] - 1 && cyc <= t[c] + d[c]) begin
            ack = C'($urandom);
            ack[c] = (cyc == t[c] + d[c]);
          end
        end
      end
      drain_ack_i = ack;
      if (mode == 3 && cyc == endc) check_all_zero("reset_mid_drain");
    end while (cyc < endc + 1);
    start_i = 1'b0; rst_i = 1'b0; pe_done_i = '0; drain_ack_i = '0;
    check("queue_drained", expq.size(), 0);
    expq.delete();
    if (kin != 0 && mode == 1) check("error_sticky", int'(error_o), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, md;
    rst_i = 1'b1; start_i = 1'b0; k_len_i = '0; pe_done_i = '0; drain_ack_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset_state");
    chk_en = 1'b1;

    run_job(3, 0);
    run_job(0, 0);
    run_job(5, 1);
    run_job(2, 0);
    run_job(4, 4);
    run_job(15, 0);
    run_job(1, 2);
    run_job(3, 3);
    run_job(2, 0);
    for (int i = 0; i < 20; i++) begin
      m  = int'($urandom_range(0, 9));
      md = (m < 6) ? 0 : (m < 8) ? 4 : (m < 9) ? 2 : 1;
      run_job(int'($urandom_range(0, 15)), md);
    end
    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
